// File: rtl/x1_multiplier.sv
// Second multiplier stage: reduces five carry-save words to one 64-bit sum,
// selects a 32-bit half and queues it in a first-word-fall-through FIFO.
module x1_multiplier #(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [319:0] RES_RX0,
  input  logic         SELECT_MSB_RX0,
  input  logic         SIGNED_RES_RX0,
  input  logic         X0X1_EMPTY_SX0,
  output logic         X0X1_POP_SX1,
  input  logic         KILL_SX1,
  input  logic         X1X2_POP_SX2,
  output logic         X1X2_EMPTY_SX1,
  output logic [31:0]  RES_RX1,
  output logic         SIGNED_RES_RX1
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  // {sum, carry}; carry is the majority vector shifted left within 64 bits
  function automatic logic [127:0] csa(input logic [63:0] a, input logic [63:0] b,
                                       input logic [63:0] c);
    logic [63:0] maj;
    maj = (a & b) | (a & c) | (b & c);
    return {a ^ b ^ c, maj[62:0], 1'b0};
  endfunction

  logic [63:0]  w [5];
  logic [127:0] lvl_a, lvl_b, lvl_c;

  always_comb begin
    for (int unsigned k = 0; k < 5; k++) begin
      w[k] = RES_RX0[64*k +: 64];
    end
    lvl_a = csa(w[0], w[1], w[2]);
    lvl_b = csa(lvl_a[127:64], lvl_a[63:0], w[3]);
    lvl_c = csa(lvl_b[127:64], lvl_b[63:0], w[4]);
  end

  // Pipeline state
  logic        v1, v2;
  logic [63:0] s1_sum, s1_carry;
  logic        s1_msb, s1_signed;
  logic [31:0] s2_res;
  logic        s2_signed;

  // Output FIFO state
  logic [32:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [32:0]   head_q;

  logic        fifo_pop, adv_s2, adv_s1, take;
  logic [63:0] final_sum;

  always_comb begin
    fifo_pop     = X1X2_POP_SX2 & (count != '0);
    adv_s2       = v2 & ((count < DEPTH_C) | fifo_pop);
    adv_s1       = v1 & (~v2 | adv_s2);
    take         = ~X0X1_EMPTY_SX0 & ~KILL_SX1 & ~reset & (~v1 | adv_s1);
    X0X1_POP_SX1 = take;
    final_sum    = s1_sum + s1_carry;
  end

  always_ff @(posedge clk) begin
    if (reset || KILL_SX1) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      if (take) begin
        v1 <= 1'b1;
      end else if (adv_s1) begin
        v1 <= 1'b0;
      end
      if (adv_s1) begin
        v2 <= 1'b1;
      end else if (adv_s2) begin
        v2 <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (take) begin
      s1_sum    <= lvl_c[127:64];
      s1_carry  <= lvl_c[63:0];
      s1_msb    <= SELECT_MSB_RX0;
      s1_signed <= SIGNED_RES_RX0;
    end
    if (adv_s1) begin
      s2_res    <= s1_msb ? final_sum[63:32] : final_sum[31:0];
      s2_signed <= s1_signed;
    end
  end

  always_ff @(posedge clk) begin
    if (adv_s2 && !reset && !KILL_SX1) begin
      mem[wr_ptr] <= {s2_signed, s2_res};
    end
  end

  always_ff @(posedge clk) begin
    if (reset || KILL_SX1) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (adv_s2) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (fifo_pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      if (adv_s2 && !fifo_pop) begin
        count <= count + 1'b1;
      end else if (fifo_pop && !adv_s2) begin
        count <= count - 1'b1;
      end
    end
  end

  // Tracks the visible head so an emptied FIFO keeps presenting the last value
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
    end else if (count != '0) begin
      head_q <= mem[rd_ptr];
    end
  end

  always_comb begin
    X1X2_EMPTY_SX1 = (count == '0);
    if (count != '0) begin
      RES_RX1        = mem[rd_ptr][31:0];
      SIGNED_RES_RX1 = mem[rd_ptr][32];
    end else begin
      RES_RX1        = head_q[31:0];
      SIGNED_RES_RX1 = head_q[32];
    end
  end

endmodule

// File: tb/tb_x1_multiplier.sv
// Bench for x1_multiplier: source queue feeds the x0x1 side, a scoreboard
// holds expected results, and a monitor checks every consumer pop.
module tb_x1_multiplier;

  typedef struct {
    logic [319:0] words;
    logic         msb;
    logic         sg;
    logic [31:0]  exp;
  } ent_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [319:0] RES_RX0 = '0;
  logic         SELECT_MSB_RX0 = 1'b0;
  logic         SIGNED_RES_RX0 = 1'b0;
  logic         X0X1_EMPTY_SX0 = 1'b1;
  logic         X0X1_POP_SX1;
  logic         KILL_SX1 = 1'b0;
  logic         X1X2_POP_SX2 = 1'b0;
  logic         X1X2_EMPTY_SX1;
  logic [31:0]  RES_RX1;
  logic         SIGNED_RES_RX1;

  x1_multiplier #(.DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .RES_RX0        (RES_RX0),
    .SELECT_MSB_RX0 (SELECT_MSB_RX0),
    .SIGNED_RES_RX0 (SIGNED_RES_RX0),
    .X0X1_EMPTY_SX0 (X0X1_EMPTY_SX0),
    .X0X1_POP_SX1   (X0X1_POP_SX1),
    .KILL_SX1       (KILL_SX1),
    .X1X2_POP_SX2   (X1X2_POP_SX2),
    .X1X2_EMPTY_SX1 (X1X2_EMPTY_SX1),
    .RES_RX1        (RES_RX1),
    .SIGNED_RES_RX1 (SIGNED_RES_RX1)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          pops = 0;
  int          out_count = 0;
  int          last_out_cyc = 0;
  logic [32:0] last_out = '0;
  logic [32:0] mon_e;

  logic rst_req = 1'b1;
  logic kill_req = 1'b0;
  int   cons_pct = 0;

  ent_t        src_q [$];
  logic [32:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // Reference: plain 64-bit modular sum of the five words, then pick a half
  function automatic logic [31:0] ref_res(input logic [319:0] words, input logic msb);
    logic [63:0] total;
    total = 64'd0;
    for (int k = 0; k < 5; k++) total = total + words[64*k +: 64];
    return msb ? total[63:32] : total[31:0];
  endfunction

  task automatic push_ent(input logic [63:0] w0, input logic [63:0] w1, input logic [63:0] w2,
                          input logic [63:0] w3, input logic [63:0] w4,
                          input logic msb, input logic sg, input logic [31:0] exp);
    ent_t e;
    e.words = {w4, w3, w2, w1, w0};
    e.msb   = msb;
    e.sg    = sg;
    e.exp   = exp;
    src_q.push_back(e);
  endtask

  task automatic push_rand();
    ent_t e;
    for (int k = 0; k < 5; k++) e.words[64*k +: 64] = {$urandom, $urandom};
    e.msb = 1'($urandom_range(1));
    e.sg  = 1'($urandom_range(1));
    e.exp = ref_res(e.words, e.msb);
    src_q.push_back(e);
  endtask

  // Driver: present source head and control, then log accepted pops
  always @(negedge clk) begin
    reset    = rst_req;
    KILL_SX1 = kill_req;
    if (src_q.size() != 0) begin
      X0X1_EMPTY_SX0 = 1'b0;
      RES_RX0        = src_q[0].words;
      SELECT_MSB_RX0 = src_q[0].msb;
      SIGNED_RES_RX0 = src_q[0].sg;
    end else begin
      X0X1_EMPTY_SX0 = 1'b1;
    end
    X1X2_POP_SX2 = ($urandom_range(99) < cons_pct);
    #2;
    if (reset || KILL_SX1) begin
      check("pop_blocked", X0X1_POP_SX1, 1'b0);
      exp_q.delete();
    end
    if (X0X1_POP_SX1) begin
      if (src_q.size() == 0) begin
        timeout("pop_when_empty");
      end else begin
        exp_q.push_back({src_q[0].sg, src_q[0].exp});
        void'(src_q.pop_front());
        pops++;
      end
    end
  end

  // Monitor: every consumer pop of a non-empty FIFO is checked in order
  always @(negedge clk) begin
    #3;
    if (!reset && !KILL_SX1 && X1X2_POP_SX2 && !X1X2_EMPTY_SX1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out: got 0x%0h with no result expected (cycle %0d)", RES_RX1, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("res", RES_RX1, mon_e[31:0]);
        check("tag", SIGNED_RES_RX1, mon_e[32]);
      end
      out_count++;
      last_out_cyc = cyc;
      last_out = {SIGNED_RES_RX1, RES_RX1};
    end
  end

  task automatic wait_pops(input int target, input string name);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #4;
      if (pops >= target) return;
    end
    timeout(name);
  endtask

  task automatic wait_drain(input int limit, input string name);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk); #4;
      if (src_q.size() == 0 && exp_q.size() == 0 && X1X2_EMPTY_SX1) return;
    end
    timeout(name);
  endtask

  task automatic check_latency(input string name);
    for (int d = 1; d <= 3; d++) begin
      @(negedge clk); #4;
      check($sformatf("%s_empty_c%0d", name, d), X1X2_EMPTY_SX1, (d < 3) ? 1'b1 : 1'b0);
    end
  endtask

  initial begin
    int base, out_base, first_cyc;
    ent_t k_ent;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_pop", X0X1_POP_SX1, 1'b0);
    check("rst_empty", X1X2_EMPTY_SX1, 1'b1);
    check("rst_res", RES_RX1, 32'h0);
    check("rst_tag", SIGNED_RES_RX1, 1'b0);
    rst_req = 1'b0;

    // Latency of a single entry through an empty pipe
    @(posedge clk);
    base = pops;
    push_ent(64'd5, 64'd7, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1, 32'h0000_000C);
    wait_pops(base + 1, "t1_pop");
    check_latency("t1");
    check("t1_res", RES_RX1, 32'h0000_000C);
    check("t1_tag", SIGNED_RES_RX1, 1'b1);
    @(posedge clk);
    cons_pct = 100;
    wait_drain(50, "t1_drain");

    // Carry into bit 32, then full wrap with carry-out dropped
    @(posedge clk);
    push_ent(64'h0000_0001_8000_0000, 64'h8000_0000, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0, 32'h0000_0002);
    push_ent(64'h0000_0001_8000_0000, 64'h8000_0000, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1, 32'h0000_0000);
    push_ent('1, '1, '1, '1, '1, 1'b1, 1'b1, 32'hFFFF_FFFF);
    push_ent('1, '1, '1, '1, '1, 1'b0, 1'b0, 32'hFFFF_FFFB);
    wait_drain(50, "t23_drain");
    @(negedge clk); #4;
    check("hold_res", RES_RX1, 32'hFFFF_FFFB);
    check("hold_tag", SIGNED_RES_RX1, 1'b0);

    // Capacity with a stalled consumer, then streaming release
    @(posedge clk);
    cons_pct = 0;
    base = pops;
    for (int i = 0; i < 6; i++) push_rand();
    repeat (12) @(negedge clk);
    #4;
    check("cap_pops", pops - base, 4);
    check("cap_pop_low", X0X1_POP_SX1, 1'b0);
    out_base = out_count;
    first_cyc = -1;
    @(posedge clk);
    cons_pct = 100;
    for (int i = 0; i < 60 && out_count - out_base < 6; i++) begin
      @(negedge clk); #4;
      if (first_cyc < 0 && out_count > out_base) first_cyc = cyc;
    end
    check("cap_outs", out_count - out_base, 6);
    check("cap_stream", last_out_cyc - first_cyc, 5);
    wait_drain(50, "cap_drain");

    // Kill with three results in flight; next entry is processed normally
    @(posedge clk);
    cons_pct = 0;
    base = pops;
    for (int i = 0; i < 3; i++) push_rand();
    wait_pops(base + 3, "kill_fill");
    @(posedge clk);
    kill_req = 1'b1;
    push_ent(64'h1234_5678_9ABC_DEF0, 64'h1, 64'h2, 64'h3, 64'h4, 1'b1, 1'b1, 32'h1234_5678);
    out_base = out_count;
    @(posedge clk);
    kill_req = 1'b0;
    @(negedge clk); #4;
    check("kill_empty", X1X2_EMPTY_SX1, 1'b1);
    check("kill_next_pop", pops - base, 4);
    check_latency("kill");
    check("kill_res", RES_RX1, 32'h1234_5678);
    check("kill_no_leak", out_count - out_base, 0);
    @(posedge clk);
    cons_pct = 100;
    wait_drain(50, "kill_drain");
    check("kill_outs", out_count - out_base, 1);

    // Reset mid-stream
    @(posedge clk);
    cons_pct = 0;
    base = pops;
    for (int i = 0; i < 4; i++) push_rand();
    wait_pops(base + 4, "rst_fill");
    repeat (3) @(negedge clk);
    @(posedge clk);
    rst_req = 1'b1;
    @(posedge clk);
    rst_req = 1'b0;
    @(negedge clk); #4;
    check("mrst_empty", X1X2_EMPTY_SX1, 1'b1);
    check("mrst_res", RES_RX1, 32'h0);
    check("mrst_tag", SIGNED_RES_RX1, 1'b0);
    check("mrst_pop", X0X1_POP_SX1, 1'b0);
    out_base = out_count;
    @(posedge clk);
    cons_pct = 100;
    push_rand();
    wait_drain(50, "mrst_drain");
    check("mrst_outs", out_count - out_base, 1);

    // Random traffic with a varying consumer rate
    @(posedge clk);
    out_base = out_count;
    for (int i = 0; i < 300; i++) push_rand();
    for (int i = 0; i < 4000 && (src_q.size() != 0 || exp_q.size() != 0); i++) begin
      @(posedge clk);
      if (i % 20 == 0) cons_pct = $urandom_range(100, 20);
    end
    @(posedge clk);
    cons_pct = 100;
    wait_drain(100, "rand_drain");
    check("rand_outs", out_count - out_base, 300);
    check("rand_sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
